// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and constants for the TDC statistics accumulator
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN
    } tdc_acc_state_t;

    localparam int DROP_W = 8;

    // Codes span 0..n inclusive, so one extra bit beyond the tap index.
    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/tdc_ch_stats.sv
// rtl/tdc_ch_stats.sv - per-channel sum/min/max tracker with input clamping
module tdc_ch_stats
    import tdc_pkg::*;
#(
    parameter int N     = 64,
    parameter int HW_W  = hw_width(N),
    parameter int SUM_W = HW_W + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             sample,
    input  logic [HW_W-1:0]  data,
    output logic [SUM_W-1:0] sum,
    output logic [HW_W-1:0]  min,
    output logic [HW_W-1:0]  max,
    output logic             clamp
);

    localparam logic [HW_W-1:0] N_CODE = HW_W'(N);

    logic [SUM_W-1:0] sum_q;
    logic [HW_W-1:0]  min_q;
    logic [HW_W-1:0]  max_q;
    logic [HW_W-1:0]  data_c;

    assign clamp  = (data > N_CODE);
    assign data_c = clamp ? N_CODE : data;

    // Outputs already include the sample presented this cycle, so the parent
    // can register a final record on the same edge that accepts the last sample.
    always_comb begin
        sum = sum_q;
        min = min_q;
        max = max_q;
        if (sample) begin
            sum = sum_q + SUM_W'(data_c);
            if (data_c < min_q) min = data_c;
            if (data_c > max_q) max = data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            min_q <= N_CODE;
            max_q <= '0;
        end else if (init) begin
            sum_q <= '0;
            min_q <= N_CODE;
            max_q <= '0;
        end else if (sample) begin
            sum_q <= sum;
            min_q <= min;
            max_q <= max;
        end
    end

endmodule

// File: rtl/tdc_stat_accum.sv
// rtl/tdc_stat_accum.sv - windowed multi-channel TDC mean/min/max accumulator
module tdc_stat_accum
    import tdc_pkg::*;
#(
    parameter int N        = 64,
    parameter int N_CH     = 2,
    parameter int LOG2_AVG = 4,
    localparam int HW_W    = hw_width(N),
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   hw_valid,
    input  logic [N_CH*HW_W-1:0]   hw_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [HW_W-1:0]        out_mean,
    output logic [HW_W-1:0]        out_min,
    output logic [HW_W-1:0]        out_max,
    output logic                   busy,
    output logic                   clamp_err,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int SUM_W                = HW_W + LOG2_AVG;
    localparam logic [LOG2_AVG-1:0] LAST_CNT = '1;
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(N_CH - 1);

    tdc_acc_state_t      state, state_n;
    logic [LOG2_AVG-1:0] cnt, cnt_n;
    logic [CH_W-1:0]     ch_n;
    logic                stats_init;
    logic                stats_sample;
    logic                clear_flags;
    logic                drop_inc;

    logic [SUM_W-1:0]    sum_v [N_CH];
    logic [HW_W-1:0]     min_v [N_CH];
    logic [HW_W-1:0]     max_v [N_CH];
    logic [N_CH-1:0]     clamp_v;

    logic [HW_W-1:0]     rec_mean;
    logic [HW_W-1:0]     rec_min;
    logic [HW_W-1:0]     rec_max;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tdc_ch_stats #(
            .N     (N),
            .HW_W  (HW_W),
            .SUM_W (SUM_W)
        ) u_stats (
            .clk    (clk),
            .rst_n  (rst_n),
            .init   (stats_init),
            .sample (stats_sample),
            .data   (hw_in[g*HW_W +: HW_W]),
            .sum    (sum_v[g]),
            .min    (min_v[g]),
            .max    (max_v[g]),
            .clamp  (clamp_v[g])
        );
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ch_n         = out_ch;
        stats_init   = 1'b0;
        stats_sample = 1'b0;
        clear_flags  = 1'b0;
        drop_inc     = 1'b0;
        if (!en) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n     = ST_ACCUM;
                        cnt_n       = '0;
                        stats_init  = 1'b1;
                        clear_flags = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (hw_valid) begin
                        stats_sample = 1'b1;
                        cnt_n        = cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state_n = ST_DRAIN;
                            ch_n    = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    drop_inc = hw_valid;
                    if (out_valid && out_ready) begin
                        if (out_ch == LAST_CH) begin
                            if (continuous) begin
                                state_n    = ST_ACCUM;
                                cnt_n      = '0;
                                stats_init = 1'b1;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            ch_n = out_ch + 1'b1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rec_mean = sum_v[ch_n][SUM_W-1:LOG2_AVG];
        rec_min  = min_v[ch_n];
        rec_max  = max_v[ch_n];
    end

    // While stalled in DRAIN the stats are frozen, so reloading keeps the record stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_mean  <= '0;
            out_min   <= '0;
            out_max   <= '0;
            busy      <= 1'b0;
            clamp_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            busy      <= (state_n != ST_IDLE);
            out_valid <= (state_n == ST_DRAIN);
            if (state_n == ST_DRAIN) begin
                out_ch   <= ch_n;
                out_mean <= rec_mean;
                out_min  <= rec_min;
                out_max  <= rec_max;
            end
            if (clear_flags) begin
                clamp_err <= 1'b0;
                drop_cnt  <= '0;
            end else begin
                if (stats_sample && |clamp_v) clamp_err <= 1'b1;
                if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_stat_accum.sv
// tb/tb_tdc_stat_accum.sv - randomized self-checking bench for tdc_stat_accum
module tb_tdc_stat_accum;

    localparam int N        = 64;
    localparam int N_CH     = 2;
    localparam int LOG2_AVG = 2;
    localparam int HW_W     = 7;
    localparam int AVG      = 1 << LOG2_AVG;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 start;
    logic                 continuous;
    logic                 hw_valid;
    logic [N_CH*HW_W-1:0] hw_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:0]           out_ch;
    logic [HW_W-1:0]      out_mean;
    logic [HW_W-1:0]      out_min;
    logic [HW_W-1:0]      out_max;
    logic                 busy;
    logic                 clamp_err;
    logic [7:0]           drop_cnt;

    tdc_stat_accum #(
        .N        (N),
        .N_CH     (N_CH),
        .LOG2_AVG (LOG2_AVG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .start      (start),
        .continuous (continuous),
        .hw_valid   (hw_valid),
        .hw_in      (hw_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_mean   (out_mean),
        .out_min    (out_min),
        .out_max    (out_max),
        .busy       (busy),
        .clamp_err  (clamp_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];
    int m_drop = 0;
    bit m_clamp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampv(input int v);
        return (v > N) ? N : v;
    endfunction

    // kind 0 = mean, 1 = min, 2 = max of the window collected for channel c
    function automatic int model_stat(input int c, input int kind);
        int s = 0;
        int mn = N;
        int mx = 0;
        int v;
        int len;
        len = (c == 0) ? q0.size() : q1.size();
        for (int i = 0; i < len; i++) begin
            v = (c == 0) ? q0[i] : q1[i];
            s += v;
            if (v < mn) mn = v;
            if (v > mx) mx = v;
        end
        case (kind)
            0:       return s / AVG;
            1:       return mn;
            default: return mx;
        endcase
    endfunction

    task automatic push2(input int a, input int b);
        hw_in    = {7'(b), 7'(a)};
        hw_valid = 1'b1;
        tick();
        hw_valid = 1'b0;
        q0.push_back(clampv(a));
        q1.push_back(clampv(b));
        if (a > N || b > N) m_clamp = 1'b1;
    endtask

    task automatic start_win(input bit cont, input bit with_hv);
        start      = 1'b1;
        continuous = cont;
        hw_valid   = with_hv;
        hw_in      = {7'd63, 7'd63};
        tick();
        start    = 1'b0;
        hw_valid = 1'b0;
        q0.delete();
        q1.delete();
        m_clamp = 1'b0;
        m_drop  = 0;
        check_eq("busy_after_start", busy, 1);
        check_eq("clamp_cleared", clamp_err, 0);
        check_eq("drop_cleared", drop_cnt, 0);
    endtask

    task automatic drain(input int stall, input int drops, input bit exp_busy);
        int w;
        int e_mean;
        int e_min;
        int e_max;
        for (int c = 0; c < N_CH; c++) begin
            w = 0;
            while (out_valid !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            e_mean = model_stat(c, 0);
            e_min  = model_stat(c, 1);
            e_max  = model_stat(c, 2);
            check_eq("rec_latency", w, 0);
            check_eq("rec_valid", out_valid, 1);
            check_eq("rec_ch", out_ch, c);
            check_eq("rec_mean", out_mean, e_mean);
            check_eq("rec_min", out_min, e_min);
            check_eq("rec_max", out_max, e_max);
            if (c == 0) begin
                for (int s = 0; s < stall; s++) begin
                    hw_valid = (s < drops);
                    tick();
                    if (hw_valid && m_drop < 255) m_drop++;
                    hw_valid = 1'b0;
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_ch", out_ch, 0);
                    check_eq("hold_mean", out_mean, e_mean);
                    check_eq("hold_min", out_min, e_min);
                    check_eq("hold_max", out_max, e_max);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check_eq("valid_after_last", out_valid, 0);
        check_eq("busy_after_last", busy, exp_busy);
        check_eq("drop_cnt", drop_cnt, m_drop);
        check_eq("clamp_err", clamp_err, m_clamp);
        q0.delete();
        q1.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_ch"}, out_ch, 0);
        check_eq({tag, "_mean"}, out_mean, 0);
        check_eq({tag, "_min"}, out_min, 0);
        check_eq({tag, "_max"}, out_max, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_clamp"}, clamp_err, 0);
        check_eq({tag, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        hw_valid   = 1'b0;
        hw_in      = '0;
        out_ready  = 1'b0;
        #23;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();

        // directed window; the strobe coincident with start must not count
        start_win(1'b0, 1'b1);
        push2(10, 40);
        push2(12, 40);
        push2(14, 41);
        push2(16, 41);
        drain(0, 0, 1'b0);

        // consumer stall with drops in DRAIN
        start_win(1'b0, 1'b0);
        push2(10, 40);
        push2(12, 40);
        push2(14, 41);
        push2(16, 41);
        drain(5, 3, 1'b0);

        // clamping, and a start in ACCUM that must be ignored
        start_win(1'b0, 1'b0);
        push2(70, 30);
        check_eq("clamp_set", clamp_err, 1);
        start = 1'b1;
        push2(10, 30);
        start = 1'b0;
        check_eq("clamp_sticky", clamp_err, 1);
        push2(12, 31);
        push2(14, 32);
        drain(0, 0, 1'b0);
        tick();
        check_eq("clamp_held_idle", clamp_err, 1);

        // drop counter saturation
        start_win(1'b0, 1'b0);
        for (int i = 0; i < AVG; i++) push2(i, 63 - i);
        drain(260, 260, 1'b0);

        // continuous mode: two windows with no busy gap
        start_win(1'b1, 1'b0);
        for (int i = 0; i < AVG; i++) push2(20, 20);
        drain(0, 0, 1'b1);
        for (int i = 0; i < AVG; i++) push2(20, 20);
        continuous = 1'b0;
        drain(0, 0, 1'b0);

        // abort via en, then a clean window
        start_win(1'b0, 1'b0);
        push2(1, 2);
        push2(3, 4);
        en = 1'b0;
        tick();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_valid", out_valid, 0);
        en = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("abort_no_record", out_valid, 0);
        end
        check_eq("abort_drop_held", drop_cnt, m_drop);
        start_win(1'b0, 1'b0);
        for (int i = 0; i < AVG; i++) push2(5, 5);
        drain(0, 0, 1'b0);

        // randomized windows
        for (int win = 0; win < 12; win++) begin
            int st;
            start_win(1'b0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < AVG; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                push2($urandom_range(0, 70), $urandom_range(0, 70));
            end
            st = $urandom_range(0, 3);
            drain(st, $urandom_range(0, st), 1'b0);
        end

        // asynchronous reset in the middle of DRAIN
        start_win(1'b0, 1'b0);
        for (int i = 0; i < AVG; i++) push2(7 + i, 50 - i);
        check_eq("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_busy", busy, 0);
        check_eq("post_reset_valid", out_valid, 0);
        start_win(1'b0, 1'b0);
        for (int i = 0; i < AVG; i++) push2(33, 2 * i);
        drain(1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_stat_accum.md
# tdc_stat_accum

Multi-channel statistics accumulator for the TDC readout path. Collects per-sample hamming-weight codes from `N_CH` parallel delay-line TDCs and accumulates 2^`LOG2_AVG` samples per measurement window. Once a window closes, it streams a per-channel mean/min/max record over a valid/ready interface. It sits between the TDC capture/synchroniser stage and the host readout logic, and replaces the single-sample `hw` output with averaged, range-checked results.

## Interface
- `N`, 64: delay-line taps per channel; `HW_W = $clog2(N)+1`, so codes span 0..N.
- `N_CH`, 2: number of TDC channels (1..8).
- `LOG2_AVG`, 4: window = 2^`LOG2_AVG` samples (1..8).
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: block enable; low aborts any window, synchronously, to IDLE.
- `start` in 1: begin a window; honoured only in IDLE.
- `continuous` in 1: when high, re-arm automatically after DRAIN.
- `hw_valid` in 1: one-cycle strobe; all channels present a sample.
- `hw_in` in `N_CH*HW_W`: channel c at bits [c*HW_W +: HW_W].
- `out_valid` out 1: result record valid.
- `out_ready` in 1: consumer accepts record.
- `out_ch` out `$clog2(N_CH)` (min 1): channel index of record.
- `out_mean`, `out_min`, `out_max` out `HW_W` each: window statistics.
- `busy` out 1: state != IDLE.
- `clamp_err` out 1: sticky; a sample > N was seen; cleared by `start` accepted.
- `drop_cnt` out 8: saturating count of `hw_valid` strobes ignored in DRAIN; cleared by `start` accepted.

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE: `start && en` -> ACCUM; sample counter, sums, `clamp_err`, `drop_cnt` cleared; min preset to N, max to 0.
- ACCUM: each `hw_valid` adds every channel sample to sum (width `HW_W+LOG2_AVG`, no overflow possible), updates min/max, increments the counter. The sample that makes count = 2^`LOG2_AVG` moves the block to DRAIN.
- Samples > N are clamped to N before use and set `clamp_err`.
- DRAIN: records presented in order ch 0..N_CH-1. `out_mean = sum >> LOG2_AVG` (truncating). Advance on `out_valid && out_ready`.
- After the last channel transfers: `continuous` high -> ACCUM with stats re-initialised (drop/err kept); otherwise -> IDLE.
- `hw_valid` in DRAIN: sample discarded, `drop_cnt` += 1, saturating at 255.
- `start` in ACCUM/DRAIN: ignored.
- `en` low in any state: next edge -> IDLE, `out_valid` deasserted, partial window lost; `clamp_err`/`drop_cnt` held.

## Timing
- Reset values: `out_valid`=0, `out_ch`=0, `out_mean`=0, `out_min`=0, `out_max`=0, `busy`=0, `clamp_err`=0, `drop_cnt`=0; state IDLE.
- `start` sampled at edge t gives `busy`=1 after t. The earliest counted `hw_valid` is the one sampled at edge t+1; a `hw_valid` coincident with `start` is not counted.
- Final sample accepted at edge t gives `out_valid`=1, `out_ch`=0 after t, so the first record is 1 cycle after the last sample.
- `out_valid` stays high with stable data until accepted. The next channel appears the cycle after a transfer, so back-to-back `out_ready` yields 1 record/cycle.
- Last transfer at edge t: `out_valid`=0 after t. With `continuous`, samples from edge t+1 count.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package `tdc_pkg`: state enum `tdc_acc_state_t`, `HW_W` derivation function, `DROP_W`=8 constant.
- Sub-module `tdc_ch_stats`: one per channel (generate loop). Holds sum/min/max registers and the clamp, with `init`, `sample`, `data` inputs and `sum`, `min`, `max`, `clamp` outputs.
- Top handles the FSM, sample counter, output mux/register, `drop_cnt`, `clamp_err`.

## Test plan
- N=64, N_CH=2, LOG2_AVG=2; ch0 samples 10,12,14,16; ch1 samples 40,40,41,41 -> record ch0 mean 13 min 10 max 16, then ch1 mean 40 min 40 max 41, `busy` drops after 2nd transfer.
- Same window with `out_ready` low 5 cycles -> ch0 record held stable 5 cycles; a `hw_valid` pulsed 3 times meanwhile -> `drop_cnt`=3.
- ch0 sample value 70 (>64) -> treated as 64, `clamp_err`=1 until next accepted `start`.
- `continuous`=1, two windows of constant 20 -> two record pairs, all mean/min/max 20, no `busy` gap between windows.
- `en` deasserted after 2 of 4 samples -> IDLE next cycle, no record emitted; restart with 4 samples of 5 -> mean 5 (no residue from aborted window).
- Async `rst_n` low mid-DRAIN -> all outputs at reset values immediately; `start` after release behaves as fresh window.
